axi3_nto1_arbiter: RTL
======================

Name: axi3_nto1_arbiter

Overview:
- Parametrised N-master to 1-slave AXI3 arbiter; in-house successor to the 2-port vendor crossbar that merges I-cache and D-cache traffic onto the single external AXI3 port.
- Independent read and write arbiters.
- Selectable round-robin or fixed priority.
- One outstanding read burst and one outstanding write burst at a time.

Parameters:
- NUM_MASTERS, 2, number of upstream masters (1..8); index 0 = D-cache, 1 = I-cache.
- ID_W, 4, AXI ID width.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; STRB_W = DATA_W/8.
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (lowest index wins).
- AX_W, derived, ID_W+ADDR_W+8+3+2+2+4+3. Address payload field order, MSB to LSB: id, addr, len[7:0], size, burst, lock, cache, prot.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- s_ar_pl  in  NUM_MASTERS*AX_W  per-master AR payload; master i at slice i.
- s_arvalid  in  NUM_MASTERS  per-master AR valid.
- s_arready  out  NUM_MASTERS  per-master AR ready.
- s_r_pl  out  ID_W+DATA_W+2+1  R payload {id, data, resp, last}, broadcast to all masters.
- s_rvalid  out  NUM_MASTERS  per-master R valid.
- s_rready  in  NUM_MASTERS  per-master R ready.
- s_aw_pl  in  NUM_MASTERS*AX_W  per-master AW payload.
- s_awvalid  in  NUM_MASTERS  per-master AW valid.
- s_awready  out  NUM_MASTERS  per-master AW ready.
- s_w_pl  in  NUM_MASTERS*(ID_W+DATA_W+STRB_W+1)  per-master W payload {id, data, strb, last}.
- s_wvalid  in  NUM_MASTERS  per-master W valid.
- s_wready  out  NUM_MASTERS  per-master W ready.
- s_b_pl  out  ID_W+2  B payload {id, resp}, broadcast.
- s_bvalid  out  NUM_MASTERS  per-master B valid.
- s_bready  in  NUM_MASTERS  per-master B ready.
- m_ar_pl/m_arvalid/m_arready  out/out/in  AX_W/1/1  downstream AR channel.
- m_r_pl/m_rvalid/m_rready  in/in/out  ID_W+DATA_W+3/1/1  downstream R channel.
- m_aw_pl/m_awvalid/m_awready  out/out/in  AX_W/1/1  downstream AW channel.
- m_w_pl/m_wvalid/m_wready  out/out/in  ID_W+DATA_W+STRB_W+1/1/1  downstream W channel.
- m_b_pl/m_bvalid/m_bready  in/in/out  ID_W+2/1/1  downstream B channel.

Behaviour:
- Reset (rst=0, async): both FSMs idle, rr pointers = 0, grants = 0. All s_*valid, s_*ready, m_*valid, m_*ready = 0. Payload outputs = 0.
- Read FSM states: R_IDLE, R_ADDR, R_DATA.
  - R_IDLE: if any s_arvalid, latch rgrant from the arbiter and go to R_ADDR. Arbitration is registered: s_arvalid at cycle t gives m_arvalid at t+1.
  - R_ADDR: m_arvalid=1; m_ar_pl = s_ar_pl[rgrant]; s_arready[rgrant] = m_arready, other bits 0. On m_arvalid&m_arready go to R_DATA.
  - R_DATA: s_rvalid[rgrant] = m_rvalid, others 0; m_rready = s_rready[rgrant]. On beat handshake with last=1 go to R_IDLE; in RR mode rr_ptr_r <= (rgrant+1) mod NUM_MASTERS.
- Write FSM states: W_IDLE, W_ADDR, W_DATA, W_RESP.
  - W_IDLE and W_ADDR: same as the read path, using wgrant.
  - W_DATA: m_wvalid = s_wvalid[wgrant]; s_wready[wgrant] = m_wready. On handshake with last=1 go to W_RESP.
  - W_RESP: route B to wgrant. On m_bvalid&m_bready go to W_IDLE and update rr_ptr_w.
  - W data is never forwarded before the AW handshake completes; s_wready stays 0 until then.
- Arbiter:
  - RR mode: first requester scanning from ptr upward with wrap-around (index NUM_MASTERS-1 wraps to 0).
  - Fixed mode: lowest asserted index wins.
  - Read and write pointers are independent.
- Read and write paths run fully concurrently; no ordering between them.
- No passthrough when idle: m_*valid are state-derived and never combinationally follow s_*valid.
- Payload muxes output 0 when not in the corresponding forwarding state.
- Downstream ID and payload fields are forwarded unmodified; responses are routed by latched grant, not by ID.
- A master dropping valid before handshake is a protocol violation; behaviour is undefined and is not checked.
- NUM_MASTERS=1: the arbiter degenerates to grant 0; the FSMs are unchanged.

Test Plan:
1. Master 1 issues AR len=3 at t, slave arready=1 -> m_arvalid=1 at t+1. 4 R beats appear on s_rvalid[1] only, s_rvalid[0]=0 throughout. Read FSM idle the cycle after rlast.
2. RR mode, masters 0 and 1 both hold arvalid for 4 back-to-back single-beat reads -> grant order 0,1,0,1.
3. Fixed mode, same stimulus as 2 -> master 0 is served until its arvalid drops. Master 1 is granted only in the following arbitration cycle.
4. Concurrent: master 1 reads len=1 while master 0 writes len=0 with wstrb=4'hF, data=32'hDEADBEEF -> both complete. m_w_pl.data=32'hDEADBEEF. s_bvalid[0]=1 with bresp=0.
5. Master 0 asserts wvalid 3 cycles before awvalid -> s_wready[0]=0 until the AW handshake. The first W beat is accepted at the earliest in the cycle after the AW handshake.
6. rst asserted during R_DATA after 2 of 4 beats -> all valid/ready outputs are 0 in the same cycle. After release, a new AR from master 0 is served normally, with rr_ptr=0.

Source files
------------

// File: rtl/axi3_nto1_arbiter.sv
// rtl/axi3_nto1_arbiter.sv - N-master to 1-slave AXI3 arbiter.
// Independent read/write arbiters with one outstanding burst per direction.
module axi3_nto1_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ID_W        = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int RR_MODE     = 1,
  localparam int STRB_W     = DATA_W / 8,
  localparam int AX_W       = ID_W + ADDR_W + 8 + 3 + 2 + 2 + 4 + 3,
  localparam int R_W        = ID_W + DATA_W + 3,
  localparam int W_W        = ID_W + DATA_W + STRB_W + 1,
  localparam int B_W        = ID_W + 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_MASTERS*AX_W-1:0] s_ar_pl,
  input  logic [NUM_MASTERS-1:0]      s_arvalid,
  output logic [NUM_MASTERS-1:0]      s_arready,
  output logic [R_W-1:0]              s_r_pl,
  output logic [NUM_MASTERS-1:0]      s_rvalid,
  input  logic [NUM_MASTERS-1:0]      s_rready,
  input  logic [NUM_MASTERS*AX_W-1:0] s_aw_pl,
  input  logic [NUM_MASTERS-1:0]      s_awvalid,
  output logic [NUM_MASTERS-1:0]      s_awready,
  input  logic [NUM_MASTERS*W_W-1:0]  s_w_pl,
  input  logic [NUM_MASTERS-1:0]      s_wvalid,
  output logic [NUM_MASTERS-1:0]      s_wready,
  output logic [B_W-1:0]              s_b_pl,
  output logic [NUM_MASTERS-1:0]      s_bvalid,
  input  logic [NUM_MASTERS-1:0]      s_bready,
  output logic [AX_W-1:0]             m_ar_pl,
  output logic                        m_arvalid,
  input  logic                        m_arready,
  input  logic [R_W-1:0]              m_r_pl,
  input  logic                        m_rvalid,
  output logic                        m_rready,
  output logic [AX_W-1:0]             m_aw_pl,
  output logic                        m_awvalid,
  input  logic                        m_awready,
  output logic [W_W-1:0]              m_w_pl,
  output logic                        m_wvalid,
  input  logic                        m_wready,
  input  logic [B_W-1:0]              m_b_pl,
  input  logic                        m_bvalid,
  output logic                        m_bready
);

  localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_e;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_e;

  rstate_e         rstate_q, rstate_d;
  wstate_e         wstate_q, wstate_d;
  logic [GW-1:0]   rgrant_q, rgrant_d, rptr_q, rptr_d;
  logic [GW-1:0]   wgrant_q, wgrant_d, wptr_q, wptr_d;

  // Pass 1 takes the first requester at or above ptr; pass 2 covers the wrap.
  function automatic logic [GW-1:0] arb(input logic [NUM_MASTERS-1:0] req,
                                        input logic [GW-1:0] ptr);
    logic [GW-1:0] g;
    logic          found;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!found && req[i] && (RR_MODE == 0 || GW'(i) >= ptr)) begin
        g     = GW'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!found && req[i]) begin
        g     = GW'(i);
        found = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [GW-1:0] nxt(input logic [GW-1:0] g);
    return (g == GW'(NUM_MASTERS - 1)) ? '0 : g + GW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rstate_q <= R_IDLE;
      wstate_q <= W_IDLE;
      rgrant_q <= '0;
      wgrant_q <= '0;
      rptr_q   <= '0;
      wptr_q   <= '0;
    end else begin
      rstate_q <= rstate_d;
      wstate_q <= wstate_d;
      rgrant_q <= rgrant_d;
      wgrant_q <= wgrant_d;
      rptr_q   <= rptr_d;
      wptr_q   <= wptr_d;
    end
  end

  always_comb begin
    rstate_d  = rstate_q;
    rgrant_d  = rgrant_q;
    rptr_d    = rptr_q;
    m_arvalid = 1'b0;
    m_ar_pl   = '0;
    s_arready = '0;
    s_rvalid  = '0;
    s_r_pl    = '0;
    m_rready  = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        if (|s_arvalid) begin
          rgrant_d = arb(s_arvalid, rptr_q);
          rstate_d = R_ADDR;
        end
      end
      R_ADDR: begin
        m_arvalid = 1'b1;
        for (int i = 0; i < NUM_MASTERS; i++) begin
          if (rgrant_q == GW'(i)) begin
            m_ar_pl      = s_ar_pl[i*AX_W +: AX_W];
            s_arready[i] = m_arready;
          end
        end
        if (m_arready) rstate_d = R_DATA;
      end
      R_DATA: begin
        s_r_pl = m_r_pl;
        for (int i = 0; i < NUM_MASTERS; i++) begin
          if (rgrant_q == GW'(i)) begin
            s_rvalid[i] = m_rvalid;
            m_rready    = s_rready[i];
            if (m_rvalid && s_rready[i] && m_r_pl[0]) begin
              rstate_d = R_IDLE;
              if (RR_MODE != 0) rptr_d = nxt(rgrant_q);
            end
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // W beats are only forwarded from W_DATA, i.e. strictly after the AW handshake.
  always_comb begin
    wstate_d  = wstate_q;
    wgrant_d  = wgrant_q;
    wptr_d    = wptr_q;
    m_awvalid = 1'b0;
    m_aw_pl   = '0;
    s_awready = '0;
    m_wvalid  = 1'b0;
    m_w_pl    = '0;
    s_wready  = '0;
    s_bvalid  = '0;
    s_b_pl    = '0;
    m_bready  = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (|s_awvalid) begin
          wgrant_d = arb(s_awvalid, wptr_q);
          wstate_d = W_ADDR;
        end
      end
      W_ADDR: begin
        m_awvalid = 1'b1;
        for (int i = 0; i < NUM_MASTERS; i++) begin
          if (wgrant_q == GW'(i)) begin
            m_aw_pl      = s_aw_pl[i*AX_W +: AX_W];
            s_awready[i] = m_awready;
          end
        end
        if (m_awready) wstate_d = W_DATA;
      end
      W_DATA: begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
          if (wgrant_q == GW'(i)) begin
            m_w_pl      = s_w_pl[i*W_W +: W_W];
            m_wvalid    = s_wvalid[i];
            s_wready[i] = m_wready;
            if (s_wvalid[i] && m_wready && s_w_pl[i*W_W]) wstate_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        s_b_pl = m_b_pl;
        for (int i = 0; i < NUM_MASTERS; i++) begin
          if (wgrant_q == GW'(i)) begin
            s_bvalid[i] = m_bvalid;
            m_bready    = s_bready[i];
            if (m_bvalid && s_bready[i]) begin
              wstate_d = W_IDLE;
              if (RR_MODE != 0) wptr_d = nxt(wgrant_q);
            end
          end
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

endmodule
